// File: rtl/adder32_mp_seq.sv
// Multi-precision add/subtract sequencer driving an external 32-bit full adder one slice per cycle.
// Optional macro ADDSEQ_OVF_FLAG_EN adds a registered signed-overflow output Ovf.
module adder32_mp_seq #(
  parameter int WORDS = 2
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                InValid,
  output logic                InReady,
  input  logic [32*WORDS-1:0] OpA,
  input  logic [32*WORDS-1:0] OpB,
  input  logic                Sub,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [32*WORDS-1:0] Result,
  output logic                CO,
`ifdef ADDSEQ_OVF_FLAG_EN
  output logic                Ovf,
`endif
  output logic [31:0]         AddIn1,
  output logic [31:0]         AddIn2,
  output logic                AddCI,
  output logic                AddEnable,
  input  logic [31:0]         AddOut,
  input  logic                AddCO
);

  localparam int W     = 32 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               sub_q, sub_d;
  logic [W-1:0]       result_q, result_d;
  logic               co_q, co_d;
  logic               out_valid_q, out_valid_d;
  logic [31:0]        b_slice;
`ifdef ADDSEQ_OVF_FLAG_EN
  logic               ovf_q, ovf_d;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    result_d    = result_q;
    co_d        = co_q;
    out_valid_d = out_valid_q;
`ifdef ADDSEQ_OVF_FLAG_EN
    ovf_d       = ovf_q;
`endif
    b_slice     = '0;
    AddIn1      = '0;
    AddIn2      = '0;
    AddCI       = 1'b0;
    AddEnable   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (InValid) begin
          a_d      = OpA;
          b_d      = OpB;
          sub_d    = Sub;
          result_d = '0;
          idx_d    = '0;
          carry_d  = Sub;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // Subtraction is A + ~B + 1: the +1 enters as the initial carry latched at accept.
        b_slice   = b_q[32*idx_q +: 32];
        AddIn1    = a_q[32*idx_q +: 32];
        AddIn2    = sub_q ? ~b_slice : b_slice;
        AddCI     = carry_q;
        AddEnable = 1'b1;
        result_d[32*idx_q +: 32] = AddOut;
        carry_d   = AddCO;
        idx_d     = idx_q + 1'b1;
        if (idx_q == IDX_W'(WORDS - 1)) begin
          co_d        = AddCO;
          out_valid_d = 1'b1;
`ifdef ADDSEQ_OVF_FLAG_EN
          ovf_d       = (AddIn1[31] == AddIn2[31]) && (AddOut[31] != AddIn1[31]);
`endif
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      // NOTE: operand and result registers are reset too, so an aborted operation leaves nothing behind.
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      result_q    <= '0;
      co_q        <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ADDSEQ_OVF_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      result_q    <= result_d;
      co_q        <= co_d;
      out_valid_q <= out_valid_d;
`ifdef ADDSEQ_OVF_FLAG_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign InReady  = (state_q == S_IDLE);
  assign OutValid = out_valid_q;
  assign Result   = result_q;
  assign CO       = co_q;
`ifdef ADDSEQ_OVF_FLAG_EN
  assign Ovf      = ovf_q;
`endif

endmodule

// File: tb/tb_adder32_mp_seq.sv
// Bench for adder32_mp_seq: WORDS=2 instance checked every cycle against a full-width arithmetic
// model, plus a WORDS=1 instance with directed checks. Both use a behavioural 32-bit adder.
module tb_adder32_mp_seq;

  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WORDS=2 instance
  logic        in_valid = 1'b0, out_ready = 1'b0, sub = 1'b0;
  logic [63:0] op_a = '0, op_b = '0;
  logic        in_ready, out_valid, co, add_ci, add_en, add_co, ovf;
  logic [63:0] result;
  logic [31:0] add_in1, add_in2, add_out;
  assign {add_co, add_out} = {1'b0, add_in1} + {1'b0, add_in2} + 33'(add_ci);

  adder32_mp_seq #(.WORDS(NW)) u_dut2 (
    .Clk(clk), .Rst_n(rst_n), .InValid(in_valid), .InReady(in_ready),
    .OpA(op_a), .OpB(op_b), .Sub(sub), .OutValid(out_valid), .OutReady(out_ready),
    .Result(result), .CO(co),
`ifdef ADDSEQ_OVF_FLAG_EN
    .Ovf(ovf),
`endif
    .AddIn1(add_in1), .AddIn2(add_in2), .AddCI(add_ci), .AddEnable(add_en),
    .AddOut(add_out), .AddCO(add_co)
  );

  // WORDS=1 instance
  logic        s_in_valid = 1'b0, s_out_ready = 1'b0, s_sub = 1'b0;
  logic [31:0] s_op_a = '0, s_op_b = '0;
  logic        s_in_ready, s_out_valid, s_co, s_add_ci, s_add_en, s_add_co, s_ovf;
  logic [31:0] s_result, s_add_in1, s_add_in2, s_add_out;
  assign {s_add_co, s_add_out} = {1'b0, s_add_in1} + {1'b0, s_add_in2} + 33'(s_add_ci);

  adder32_mp_seq #(.WORDS(1)) u_dut1 (
    .Clk(clk), .Rst_n(rst_n), .InValid(s_in_valid), .InReady(s_in_ready),
    .OpA(s_op_a), .OpB(s_op_b), .Sub(s_sub), .OutValid(s_out_valid), .OutReady(s_out_ready),
    .Result(s_result), .CO(s_co),
`ifdef ADDSEQ_OVF_FLAG_EN
    .Ovf(s_ovf),
`endif
    .AddIn1(s_add_in1), .AddIn2(s_add_in2), .AddCI(s_add_ci), .AddEnable(s_add_en),
    .AddOut(s_add_out), .AddCO(s_add_co)
  );

`ifndef ADDSEQ_OVF_FLAG_EN
  assign ovf   = 1'b0;
  assign s_ovf = 1'b0;
`endif

  int n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- model: full-width arithmetic, indexed by cycles since accept ----------------
  function automatic logic [64:0] wide_sum(input logic [63:0] a, input logic [63:0] bp, input logic cin);
    return {1'b0, a} + {1'b0, bp} + 65'(cin);
  endfunction

  function automatic logic wide_ovf(input logic [63:0] a, input logic [63:0] bp, input logic cin);
    logic [64:0] s;
    s = wide_sum(a, bp, cin);
    return (a[63] == bp[63]) && (s[63] != a[63]);
  endfunction

  // carry into slice k = carry out of the low 32*k bits of the full-width sum
  function automatic logic slice_carry(input logic [63:0] a, input logic [63:0] bp, input logic cin, input int k);
    logic [64:0] mask, s;
    if (k == 0) return cin;
    mask = (65'd1 << (32 * k)) - 65'd1;
    s = ({1'b0, a} & mask) + ({1'b0, bp} & mask) + 65'(cin);
    return s[32 * k];
  endfunction

  int          m_cnt = -1;   // -1: idle, 0..NW-1: slices elapsed, NW: result presented
  logic        m_valid = 1'b0, m_sub = 1'b0, m_co = 1'b0, m_ovf = 1'b0;
  logic [63:0] m_a = '0, m_bp = '0, m_res = '0;
  logic        cmp_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cnt <= -1; m_valid <= 1'b0; m_res <= '0; m_co <= 1'b0; m_ovf <= 1'b0;
    end else if (m_cnt < 0) begin
      if (in_valid) begin
        m_a <= op_a; m_bp <= sub ? ~op_b : op_b; m_sub <= sub; m_cnt <= 0;
      end
    end else if (m_cnt < NW) begin
      if (m_cnt == NW - 1) begin
        {m_co, m_res} <= wide_sum(m_a, m_bp, m_sub);
        m_ovf   <= wide_ovf(m_a, m_bp, m_sub);
        m_valid <= 1'b1;
      end
      m_cnt <= m_cnt + 1;
    end else if (out_ready) begin
      m_valid <= 1'b0; m_cnt <= -1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready", in_ready, m_cnt < 0);
      check("out_valid", out_valid, m_valid);
      if (m_cnt >= 0 && m_cnt < NW) begin
        check("add_en", add_en, 1'b1);
        check("add_in1", add_in1, m_a[m_cnt*32 +: 32]);
        check("add_in2", add_in2, m_bp[m_cnt*32 +: 32]);
        check("add_ci", add_ci, slice_carry(m_a, m_bp, m_sub, m_cnt));
      end else begin
        check("add_idle", {add_en, add_ci, add_in1, add_in2}, '0);
      end
      if (m_valid) begin
        check("result", result, m_res);
        check("co", co, m_co);
`ifdef ADDSEQ_OVF_FLAG_EN
        check("ovf", ovf, m_ovf);
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_done(output int lat, output logic ci2);
    lat = 0; ci2 = 1'b0;
    while (!out_valid && lat < 8) begin
      if (lat == 1) ci2 = add_ci;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                       input logic [63:0] exp_res, input logic exp_co, output logic ci2);
    int lat;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; in_valid = 1'b1; out_ready = 1'b0;
    check("ready_before_op", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;   // post-accept changes must be ignored
    wait_done(lat, ci2);
    check("latency", lat, NW);
    check("result_lit", result, exp_res);
    check("co_lit", co, exp_co);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("back_idle", in_ready, 1'b1);
  endtask

  initial begin
    int   lat;
    logic ci2;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_result", result, '0);
    check("rst_flags", {co, out_valid, add_en}, '0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", in_ready, 1'b1);

    // WORDS=1: single RUN cycle
    s_op_a = 32'h3E037E1A; s_op_b = 32'h5ED86C3D; s_sub = 1'b0; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    check("w1_run", {s_add_en, s_add_ci, s_in_ready, s_out_valid}, 4'b1000);
    check("w1_in1", s_add_in1, 32'h3E037E1A);
    @(negedge clk);
    check("w1_valid", s_out_valid, 1'b1);
    check("w1_result", s_result, 32'h9CDBEA57);
    check("w1_co", s_co, 1'b0);
`ifdef ADDSEQ_OVF_FLAG_EN
    check("w1_ovf", s_ovf, 1'b1);
`endif
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    check("w1_idle", {s_in_ready, s_out_valid}, 2'b10);

    // WORDS=2 directed
    do_op(64'h00000000_FFFFFFFF, 64'h1, 1'b0, 64'h00000001_00000000, 1'b0, ci2);
    check("carry_slice1", ci2, 1'b1);
    do_op(64'd5, 64'd7, 1'b1, 64'hFFFFFFFF_FFFFFFFE, 1'b0, ci2);
    do_op(64'd7, 64'd5, 1'b1, 64'd2, 1'b1, ci2);
    do_op(64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b1, 64'h02468ACF_13579BCF, 1'b1, ci2);

    // Back-pressure with a pending new request
    @(negedge clk);
    op_a = '1; op_b = '1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    op_a = 64'd7; op_b = 64'd5; sub = 1'b1;
    check("bp_busy", in_ready, 1'b0);
    wait_done(lat, ci2);
    check("bp_latency", lat, NW);
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", in_ready, 1'b0);
      check("bp_hold", {out_valid, co, result}, {2'b11, 64'hFFFFFFFF_FFFFFFFE});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release", {in_ready, out_valid}, 2'b10);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_accept", in_ready, 1'b0);
    wait_done(lat, ci2);
    check("bp2_latency", lat, NW);
    check("bp2_result", {co, result}, {1'b1, 64'd2});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset during the first RUN cycle aborts the operation
    op_a = 64'h00000000_FFFFFFFF; op_b = 64'h1; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("abort_running", add_en, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_state", {in_ready, out_valid, co, add_en}, 4'b1000);
    check("abort_result", result, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_valid", out_valid, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/adder32_mp_seq.md
Name: adder32_mp_seq

Overview:
Multi-precision add/subtract sequencer for the team's 32-bit gate-level full adder. It accepts a WORDS×32-bit operand pair over a valid/ready handshake and steps the external adder through one 32-bit slice per cycle, least-significant slice first, chaining carry between slices. It owns the adder's In1/In2/CI/Enable inputs and captures Out/CO into a wide result register. It sits between the ALU control path and the adder instance.

Parameters:
WORDS, 2, number of 32-bit slices per operation (legal range 1..8); operand/result width is 32*WORDS.

Ports:
Clk  in  1  system clock, rising-edge.
Rst_n  in  1  synchronous active-low reset.
InValid  in  1  operand pair valid.
InReady  out  1  block can accept an operation; high only in IDLE.
OpA  in  32*WORDS  first operand.
OpB  in  32*WORDS  second operand.
Sub  in  1  0: A+B, 1: A-B.
OutValid  out  1  Result/CO valid.
OutReady  in  1  consumer accepts the result.
Result  out  32*WORDS  sum/difference, mod 2^(32*WORDS).
CO  out  1  final carry out; in subtract mode 1 means no borrow.
AddIn1  out  32  to adder In1.
AddIn2  out  32  to adder In2.
AddCI  out  1  to adder CI.
AddEnable  out  1  to adder Enable.
AddOut  in  32  from adder Out; combinational in AddIn1/AddIn2/AddCI.
AddCO  in  1  from adder CO.

Behaviour:
- One clock. Reset is synchronous and active-low: all state is updated only on the rising edge of Clk, and Rst_n is sampled there.
- Reset values: state IDLE, Result=0, CO=0, OutValid=0, slice index=0, carry=0. AddIn1, AddIn2, AddCI and AddEnable are 0 whenever the state is not RUN. InReady is decoded as (state==IDLE) and is 1 in the first cycle after reset release.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with InValid && InReady:
  - latch OpA, OpB and Sub;
  - clear Result to 0;
  - set idx=0 and carry=Sub;
  - go to RUN.
- RUN: the block drives:
  - AddIn1 = A[idx];
  - AddIn2 = Sub ? ~B[idx] : B[idx];
  - AddCI = carry;
  - AddEnable = 1.
  On each edge it writes AddOut into Result[idx], sets carry<=AddCO and increments idx. At idx==WORDS-1 it sets CO<=AddCO and OutValid<=1, then goes to DONE.
- DONE: Result, CO and OutValid are held. On an edge with OutReady=1 it clears OutValid and returns to IDLE.
- Latency: OutValid rises WORDS edges after the accepting edge. Minimum initiation interval is WORDS+2 cycles when OutReady is held high.
- WORDS=1: a single RUN cycle; CO comes straight from that slice.
- OpA, OpB and Sub changing after acceptance have no effect, because the operands are latched.
- InValid asserted in RUN or DONE is ignored: InReady=0, so no accept happens.
- Rst_n low in any state, including mid-RUN, aborts the operation at that edge and forces every register to its reset value. No partial result is presented.

Optional Feature:
ADDSEQ_OVF_FLAG_EN.
- Defined: adds an output Ovf, 1 bit, registered. It is the two's-complement signed overflow of the full-width operation: Ovf = (A_msb == B'_msb) && (Result_msb != A_msb), where B' is the possibly-inverted B. It is written together with CO, valid while OutValid=1, and reset to 0.
- Undefined: the Ovf port and its logic are absent, and all other behaviour is identical.

Test Plan:
- WORDS=1, OpA=0x3E037E1A, OpB=0x5ED86C3D, Sub=0 -> Result=0x9CDBEA57, CO=0, OutValid one edge after accept; with macro, Ovf=1.
- WORDS=2, A=0x00000000_FFFFFFFF, B=0x00000000_00000001, Sub=0 -> Result=0x00000001_00000000, CO=0. Check AddCI=1 in the second RUN cycle and OutValid 2 edges after accept.
- WORDS=2, Sub=1, A=5, B=7 -> Result=0xFFFFFFFF_FFFFFFFE, CO=0. Then A=7, B=5 -> Result=2, CO=1.
- WORDS=2, A=B=0xFFFFFFFF_FFFFFFFF, Sub=0 -> Result=0xFFFFFFFF_FFFFFFFE, CO=1.
- Back-pressure: hold OutReady=0 for 5 cycles with InValid=1 and new operands -> InReady=0 and Result/CO stable throughout. Then OutReady=1 -> return to IDLE, and the next operation is accepted on the following edge.
- Drive Rst_n=0 in the first RUN cycle -> next cycle shows state IDLE, Result=0, CO=0, OutValid=0, AddEnable=0, and no OutValid pulse ever appears for the aborted operation.
